// File: rtl/frame_stream_pkg.sv
// Shared types for the frame stream transmitter: FSM states, counter width, test-pattern helper.
package frame_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    V_FRONT,
    ACTIVE,
    H_BLANK,
    V_BACK,
    V_GAP
  } tx_state_e;

  localparam int unsigned CNT_W = 16;

  // Generated pixel value before truncation to the pixel width: x + y.
  function automatic logic [31:0] pattern_sum(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

endpackage

// File: rtl/frame_stream_tx_ram.sv
// Two-bank line buffer: fill side writes a whole line per bank, read side returns data 1 cycle after rd_en_i.
// Fill stalls (bank full) until the read side releases the bank it is draining.
module line_pingpong_ram
  import frame_stream_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_DEPTH      = 258
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          clr_i,
  input  logic                          wr_en_i,
  input  logic [P_DATA_WIDTH-1:0]       wr_data_i,
  output logic                          fill_full_o,
  output logic                          wr_line_done_o,
  input  logic                          rd_en_i,
  input  logic [$clog2(P_DEPTH)-1:0]    rd_addr_i,
  input  logic                          rd_release_i,
  output logic                          rd_full_o,
  output logic [P_DATA_WIDTH-1:0]       rd_data_o
);

  localparam int unsigned AW = $clog2(P_DEPTH);

  logic [P_DATA_WIDTH-1:0] mem [2][P_DEPTH];
  logic [1:0]              full_q, full_d;
  logic                    fill_q, fill_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [P_DATA_WIDTH-1:0] rd_data_q;
  logic                    wr_fire;
  logic                    wr_last;

  assign wr_fire        = wr_en_i && !full_q[fill_q];
  assign wr_last        = wr_fire && (wr_ptr_q == AW'(P_DEPTH - 1));
  assign fill_full_o    = full_q[fill_q];
  assign rd_full_o      = full_q[rd_bank_q];
  assign wr_line_done_o = wr_last;
  assign rd_data_o      = rd_data_q;

  always_comb begin
    full_d    = full_q;
    fill_d    = fill_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    if (wr_fire) begin
      if (wr_last) begin
        full_d[fill_q] = 1'b1;
        fill_d         = ~fill_q;
        wr_ptr_d       = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    // A released bank is always full, so it can never be the bank being written this cycle.
    if (rd_release_i) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (clr_i) begin
      full_d    = '0;
      fill_d    = 1'b0;
      rd_bank_d = 1'b0;
      wr_ptr_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire) mem[fill_q][wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q    <= '0;
      fill_q    <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      full_q    <= full_d;
      fill_q    <= fill_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_data_q <= rd_en_i ? mem[rd_bank_q][rd_addr_i] : '0;
    end
  end

endmodule

// File: rtl/frame_stream_tx.sv
// Frame transmitter: gap-free h_sync lines of P_IMAGE_WIDTH, outputs registered (1 cycle after FSM state).
// Upstream stalled while the fill bank is full; FRAME_TX_PATTERN_EN adds an internal x+y pattern source.
module frame_stream_tx
  import frame_stream_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH   = 8,
  parameter int unsigned P_IMAGE_WIDTH  = 258,
  parameter int unsigned P_IMAGE_HEIGHT = 258,
  parameter int unsigned P_H_BLANK      = 16,
  parameter int unsigned P_V_FRONT      = 4,
  parameter int unsigned P_V_BACK       = 8,
  parameter int unsigned P_V_GAP        = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
`ifdef FRAME_TX_PATTERN_EN
  input  logic                    i_pattern_en,
`endif
  input  logic                    i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0] i_pix_data,
  output logic                    o_pix_ready,
  output logic                    o_h_sync,
  output logic                    o_v_sync,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_underrun
);

  localparam int unsigned AW = $clog2(P_IMAGE_WIDTH);
  localparam int unsigned LW = $clog2(P_IMAGE_HEIGHT + 1);
  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(P_IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(P_H_BLANK - 1);
  localparam logic [CNT_W-1:0] VF_LAST = CNT_W'(P_V_FRONT - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(P_V_BACK - 1);
  localparam logic [CNT_W-1:0] VG_LAST = CNT_W'(P_V_GAP - 1);

  tx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        x_q, x_d;
  logic [LW-1:0]           y_q, y_d;
  logic [LW-1:0]           fetched_q;
  logic                    urun_q, urun_d;
  logic                    h_sync_q, v_sync_q, frame_done_q, underrun_q;
  logic                    rd_en, rd_release, underrun_p, frame_done_p;
  logic                    fill_full, rd_full, wr_line_done, wr_en, busy, can_fill;
  logic [P_DATA_WIDTH-1:0] wr_data, rd_data;

  assign busy     = (state_q != IDLE);
  assign can_fill = busy && !fill_full && (fetched_q < LW'(P_IMAGE_HEIGHT));

`ifdef FRAME_TX_PATTERN_EN
  logic             pat_q;
  logic [CNT_W-1:0] pat_x_q;

  assign o_pix_ready = can_fill && !pat_q;
  assign wr_en       = pat_q ? can_fill : (i_pix_valid && o_pix_ready);
  assign wr_data     = pat_q ? P_DATA_WIDTH'(pattern_sum(32'(pat_x_q), 32'(fetched_q))) : i_pix_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat_q   <= 1'b0;
      pat_x_q <= '0;
    end else if (state_q == IDLE) begin
      pat_x_q <= '0;
      if (i_start) pat_q <= i_pattern_en;
    end else if (wr_en) begin
      pat_x_q <= (pat_x_q == X_LAST) ? '0 : pat_x_q + 1'b1;
    end
  end
`else
  assign o_pix_ready = can_fill;
  assign wr_en       = i_pix_valid && can_fill;
  assign wr_data     = i_pix_data;
`endif

  line_pingpong_ram #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_DEPTH      (P_IMAGE_WIDTH)
  ) u_ram (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .clr_i          (state_q == IDLE),
    .wr_en_i        (wr_en),
    .wr_data_i      (wr_data),
    .fill_full_o    (fill_full),
    .wr_line_done_o (wr_line_done),
    .rd_en_i        (rd_en),
    .rd_addr_i      (x_q[AW-1:0]),
    .rd_release_i   (rd_release),
    .rd_full_o      (rd_full),
    .rd_data_o      (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    urun_d       = urun_q;
    rd_en        = 1'b0;
    rd_release   = 1'b0;
    underrun_p   = 1'b0;
    frame_done_p = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = PREFILL;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          urun_d  = 1'b0;
        end
      end
      PREFILL: if (rd_full) state_d = V_FRONT;
      V_FRONT: begin
        if (cnt_q == VF_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        rd_en = 1'b1;
        if (x_q == X_LAST) begin
          rd_release = 1'b1;
          x_d        = '0;
          cnt_d      = '0;
          urun_d     = 1'b0;
          if (y_q == LW'(P_IMAGE_HEIGHT - 1)) begin
            state_d = V_BACK;
          end else begin
            state_d = H_BLANK;
            y_d     = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      H_BLANK: begin
        // Counter parks on its last value; the line starts as soon as its bank completes.
        if (cnt_q == HB_LAST) begin
          if (rd_full) begin
            state_d = ACTIVE;
          end else if (!urun_q) begin
            underrun_p = 1'b1;
            urun_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      V_BACK: begin
        if (cnt_q == VB_LAST) begin
          state_d      = V_GAP;
          cnt_d        = '0;
          frame_done_p = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      V_GAP: begin
        if (cnt_q == VG_LAST) state_d = IDLE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      urun_q       <= 1'b0;
      fetched_q    <= '0;
      h_sync_q     <= 1'b0;
      v_sync_q     <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      urun_q       <= urun_d;
      if (state_q == IDLE)   fetched_q <= '0;
      else if (wr_line_done) fetched_q <= fetched_q + 1'b1;
      // Syncs follow the state by one cycle so they line up with the RAM read data.
      h_sync_q     <= (state_q == ACTIVE);
      v_sync_q     <= (state_q inside {V_FRONT, ACTIVE, H_BLANK, V_BACK});
      frame_done_q <= frame_done_p;
      underrun_q   <= underrun_p;
    end
  end

  assign o_h_sync     = h_sync_q;
  assign o_v_sync     = v_sync_q;
  assign o_data       = rd_data;
  assign o_busy       = busy;
  assign o_frame_done = frame_done_q;
  assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Scoreboard bench for frame_stream_tx: accepted pixels queued, a negedge monitor checks stream timing and data.
module tb_frame_stream_tx;
  localparam int W = 8, H = 4, HB = 16, VF = 4, VB = 8, VG = 16;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready, h_sync, v_sync, busy, frame_done, underrun;
  logic [7:0] data;
`ifdef FRAME_TX_PATTERN_EN
  logic       pat_en = 1'b0;
`endif

  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  bit abort = 1'b0;

  always #5 clk = ~clk;

  frame_stream_tx #(
    .P_DATA_WIDTH(8), .P_IMAGE_WIDTH(W), .P_IMAGE_HEIGHT(H), .P_H_BLANK(HB),
    .P_V_FRONT(VF), .P_V_BACK(VB), .P_V_GAP(VG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
`ifdef FRAME_TX_PATTERN_EN
    .i_pattern_en(pat_en),
`endif
    .i_pix_valid(pix_valid), .i_pix_data(pix_data), .o_pix_ready(pix_ready),
    .o_h_sync(h_sync), .o_v_sync(v_sync), .o_data(data), .o_busy(busy),
    .o_frame_done(frame_done), .o_underrun(underrun)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor state: the stream rules expressed as run lengths of h_sync/v_sync.
  int  run_len, gap_len, front_len, vlow_len, lines, urun_gap, lines_busy, fd_busy;
  int  tot_urun = 0, tot_fd = 0;
  bit  prev_h, prev_v, prev_busy, seen_vfall;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0; gap_len = 0; front_len = 0; vlow_len = 0; lines = 0; urun_gap = 0;
      lines_busy = 0; fd_busy = 0; prev_h = 0; prev_v = 0; prev_busy = 0; seen_vfall = 0;
    end else begin
      if (underrun)   begin urun_gap++; tot_urun++; end
      if (frame_done) begin fd_busy++;  tot_fd++;   end
      if (busy && !prev_busy) begin lines_busy = 0; fd_busy = 0; end
      if (h_sync) begin
        check("hsync_needs_vsync", v_sync, 1);
        if (!prev_h) begin
          if (lines == 0) check("v_front_len", front_len, VF);
          else begin
            check("underrun_per_gap", urun_gap, (gap_len > HB) ? 1 : 0);
            if (urun_gap == 0) check("h_blank_len", gap_len, HB);
          end
          lines++; lines_busy++; run_len = 0; urun_gap = 0;
        end
        run_len++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pixel_queue: got pixel %0d, expected none pending", data);
        end else check("pixel_data", data, exp_q.pop_front());
      end else begin
        check("data_zero_blank", data, 0);
        if (prev_h) begin check("h_active_len", run_len, W); gap_len = 0; end
        if (v_sync) begin
          if (lines == 0) front_len++;
          else            gap_len++;
        end
      end
      if (!v_sync && prev_v) begin
        check("v_back_len", gap_len, VB);
        check("lines_per_frame", lines, H);
        lines = 0; front_len = 0; gap_len = 0; vlow_len = 0; seen_vfall = 1;
      end
      if (v_sync && !prev_v && seen_vfall) check("v_gap_min", (vlow_len >= VG) ? 1 : 0, 1);
      if (!v_sync) vlow_len++;
      if (!busy && prev_busy) begin
        check("frame_done_per_busy", fd_busy, 1);
        check("lines_per_busy", lines_busy, H);
      end
      prev_h = h_sync; prev_v = v_sync; prev_busy = busy;
    end
  end

  // Upstream source: 'duty' percent valid, optional stall once 'stall_at' pixels are accepted.
  task automatic feed(input int n, input int duty, input bit seq, input int base,
                      input int stall_at, input int stall_len);
    int sent, budget, stall;
    logic [7:0] val;
    sent = 0; budget = 0; stall = 0;
    val = seq ? 8'(base) : 8'($urandom);
    while (sent < n && !abort) begin
      @(negedge clk);
      if (abort) break;
      budget++;
      if (budget > 4000) begin
        total++; bad++;
        $display("FAIL feed_timeout: accepted %0d, expected %0d", sent, n);
        break;
      end
      if (sent == stall_at && stall < stall_len) begin
        stall++;
        pix_valid = 1'b0;
      end else begin
        pix_valid = ($urandom_range(99) < duty);
        pix_data  = val;
        if (pix_valid && pix_ready) begin
          exp_q.push_back(val);
          sent++;
          val = seq ? 8'(base + sent) : 8'($urandom);
        end
      end
    end
    if (!abort) @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check("frame_end_timeout", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, pix_ready, 0);
    check({tag, "_hsync"}, h_sync, 0);
    check({tag, "_vsync"}, v_sync, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  int u0, fd0, n;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Frame 1: always-valid ramp 0..31, no stretched blanking allowed.
    u0 = tot_urun; fd0 = tot_fd;
    start_frame();
    feed(W * H, 100, 1, 0, -1, 0);
    wait_idle();
    check("f1_underruns", tot_urun - u0, 0);
    check("f1_frame_done", tot_fd - fd0, 1);
    check("f1_queue_left", exp_q.size(), 0);
    check("f1_ready_idle", pix_ready, 0);

    // Frame 2: upstream withheld mid line 2, plus a stray start pulse that must be ignored.
    u0 = tot_urun; fd0 = tot_fd;
    start_frame();
    fork
      feed(W * H, 100, 1, 100, 2 * W + 4, 40);
      begin
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_idle();
    check("f2_underruns", tot_urun - u0, 1);
    check("f2_frame_done", tot_fd - fd0, 1);
    check("f2_queue_left", exp_q.size(), 0);

    // Frames 3-4: random data, 50% valid duty, back to back.
    fd0 = tot_fd;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      feed(W * H, 50, 0, 0, -1, 0);
      wait_idle();
    end
    check("f34_frame_done", tot_fd - fd0, 2);
    check("f34_queue_left", exp_q.size(), 0);

    // Reset while line 1 is on the wire, then a clean frame.
    start_frame();
    fork
      feed(W * H, 100, 1, 200, -1, 0);
      begin
        n = 0;
        while (!(lines == 2 && h_sync) && n < 2000) begin @(negedge clk); n++; end
        check("reset_point_reached", (n < 2000) ? 1 : 0, 1);
        abort = 1'b1;
        pix_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
    fd0 = tot_fd;
    start_frame();
    feed(W * H, 100, 1, 7, -1, 0);
    wait_idle();
    check("f5_frame_done", tot_fd - fd0, 1);
    check("f5_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
